// File: rtl/bin_binary_search.sv
`default_nettype none
//==============================================================================
// Module   : bin_binary_search
// Brief    : Latches a 6-digit card BIN and binary-searches a sorted ROM table.
//            Reports the matching index with level done/found flags that the
//            downstream brand lookup consumes directly.
// Revision : 1.0 - initial release
//==============================================================================
module bin_binary_search #(
  parameter int DEPTH     = 2638,
  parameter int ADDR_W    = 12,
  parameter int KEY_W     = 20,
  parameter     INIT_FILE = "./bindb/bin_numbers.mif"
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              start,
  input  logic [KEY_W-1:0]  target_bin,
  output logic              busy,
  output logic [ADDR_W-1:0] found_index,
  output logic              binary_search_done,
  output logic              binary_search_found
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_addr   = 3'd1;
  localparam logic [2:0] c_st_read   = 3'd2;
  localparam logic [2:0] c_st_cmp    = 3'd3;
  localparam logic [2:0] c_st_finish = 3'd4;
  localparam logic [2:0] c_st_done   = 3'd5;

  // Search bounds carry one extra bit: low may reach DEPTH and high may step to -1.
  localparam logic [ADDR_W:0] c_high_init = (ADDR_W + 1)'(DEPTH - 1);

  logic [2:0]        r_state, w_state_nxt;
  logic [KEY_W-1:0]  r_key, w_key_nxt;
  logic [ADDR_W:0]   r_low, w_low_nxt;
  logic [ADDR_W:0]   r_high, w_high_nxt;
  logic [ADDR_W:0]   r_mid, w_mid_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [ADDR_W-1:0] r_index, w_index_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_found, w_found_nxt;
  logic [KEY_W-1:0]  r_data;

  logic              w_accept;
  logic              w_exhausted;
  logic [ADDR_W+1:0] w_sum;
  logic [ADDR_W:0]   w_mid_calc;

  // A new request is taken only when no search is in flight.
  assign w_accept    = start && ((r_state == c_st_idle) || (r_state == c_st_done));
  // low is never negative; high may be -1, so compare with high sign-extended.
  assign w_exhausted = $signed({1'b0, r_low}) > $signed({r_high[ADDR_W], r_high});
  assign w_sum       = {1'b0, r_low} + {1'b0, r_high};
  assign w_mid_calc  = w_sum[ADDR_W+1:1];

  // The init-file attribute is attached only when a file is supplied.
  generate
    if (INIT_FILE != "") begin : g_rom_file
      (* ram_init_file = INIT_FILE *)
      logic [KEY_W-1:0] r_table [0:DEPTH-1] = '{default: '0};
      // Synchronous ROM read from the registered probe address.
      always_ff @(posedge CLOCK_50) begin
        r_data <= r_table[r_addr];
      end
    end else begin : g_rom_blank
      logic [KEY_W-1:0] r_table [0:DEPTH-1] = '{default: '0};
      // Synchronous ROM read from the registered probe address.
      always_ff @(posedge CLOCK_50) begin
        r_data <= r_table[r_addr];
      end
    end
  endgenerate

  // State register.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_state <= c_st_idle;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode: three cycles per probe (address, read, compare).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:   if (w_accept) w_state_nxt = c_st_addr;
      c_st_addr:   w_state_nxt = w_exhausted ? c_st_finish : c_st_read;
      c_st_read:   w_state_nxt = c_st_cmp;
      c_st_cmp:    w_state_nxt = (r_data == r_key) ? c_st_finish : c_st_addr;
      c_st_finish: w_state_nxt = c_st_done;
      c_st_done:   if (w_accept) w_state_nxt = c_st_addr;
      default:     w_state_nxt = c_st_idle;
    endcase
  end

  // Datapath and output updates per state; everything holds by default.
  always_comb begin
    w_key_nxt   = r_key;
    w_low_nxt   = r_low;
    w_high_nxt  = r_high;
    w_mid_nxt   = r_mid;
    w_addr_nxt  = r_addr;
    w_index_nxt = r_index;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_found_nxt = r_found;
    case (r_state)
      c_st_idle, c_st_done: begin
        if (w_accept) begin
          w_key_nxt   = target_bin;
          w_low_nxt   = '0;
          w_high_nxt  = c_high_init;
          w_index_nxt = '0;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_found_nxt = 1'b0;
        end
      end
      c_st_addr: begin
        if (!w_exhausted) begin
          w_mid_nxt  = w_mid_calc;
          w_addr_nxt = w_mid_calc[ADDR_W-1:0];
        end
      end
      c_st_cmp: begin
        if (r_data == r_key) begin
          w_index_nxt = r_mid[ADDR_W-1:0];
          w_found_nxt = 1'b1;
        end else if (r_data < r_key) begin
          w_low_nxt = r_mid + 1'b1;
        end else begin
          // At mid = 0 this yields all-ones, read as -1 by the exhaustion test.
          w_high_nxt = r_mid - 1'b1;
        end
      end
      c_st_finish: begin
        w_done_nxt = 1'b1;
        w_busy_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers; an asynchronous reset discards any partial result.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_key   <= '0;
      r_low   <= '0;
      r_high  <= c_high_init;
      r_mid   <= '0;
      r_addr  <= '0;
      r_index <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_found <= 1'b0;
    end else begin
      r_key   <= w_key_nxt;
      r_low   <= w_low_nxt;
      r_high  <= w_high_nxt;
      r_mid   <= w_mid_nxt;
      r_addr  <= w_addr_nxt;
      r_index <= w_index_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_found <= w_found_nxt;
    end
  end

  assign busy                = r_busy;
  assign found_index         = r_index;
  assign binary_search_done  = r_done;
  assign binary_search_found = r_found;

endmodule
`default_nettype wire

// File: tb/tb_bin_binary_search.sv
`default_nettype none
//==============================================================================
// Module   : tb_bin_binary_search
// Brief    : Directed self-checking bench for bin_binary_search using an
//            8-entry table {100000, 200000, ..., 800000}.
// Revision : 1.0 - initial release
//==============================================================================
module tb_bin_binary_search;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int KEY_W  = 20;

  logic              CLOCK_50;
  logic              resetn;
  logic              start;
  logic [KEY_W-1:0]  target_bin;
  logic              busy;
  logic [ADDR_W-1:0] found_index;
  logic              binary_search_done;
  logic              binary_search_found;

  int checks = 0;
  int errors = 0;

  bin_binary_search #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .KEY_W     (KEY_W),
    .INIT_FILE ("")
  ) dut (
    .CLOCK_50            (CLOCK_50),
    .resetn              (resetn),
    .start               (start),
    .target_bin          (target_bin),
    .busy                (busy),
    .found_index         (found_index),
    .binary_search_done  (binary_search_done),
    .binary_search_found (binary_search_found)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // Pulse start for exactly one rising edge; returns 1 ns after that edge.
  task automatic do_start(input logic [KEY_W-1:0] bin);
    @(negedge CLOCK_50);
    start      = 1'b1;
    target_bin = bin;
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen; also note whether busy stayed high meanwhile.
  task automatic wait_done(input int budget, output int cycles, output bit timed_out,
                           output bit busy_ok);
    cycles    = 0;
    timed_out = 1'b1;
    busy_ok   = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLOCK_50);
      #1;
      cycles++;
      if (binary_search_done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    resetn     = 1'b0;
    start      = 1'b1;
    target_bin = 20'd400000;
    repeat (3) @(negedge CLOCK_50);
    checks++;
    if ({busy, binary_search_done, binary_search_found, found_index} !== 6'b0) begin
      errors++;
      $display("FAIL reset_with_start: got busy=%b done=%b found=%b idx=%0d required all 0",
               busy, binary_search_done, binary_search_found, found_index);
    end
    start  = 1'b0;
    resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    checks++;
    if ({busy, binary_search_done, binary_search_found, found_index} !== 6'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b done=%b found=%b idx=%0d required all 0",
               busy, binary_search_done, binary_search_found, found_index);
    end
  endtask

  // Middle hit, both boundary hits, and misses below, between and above entries.
  task automatic test_lookups;
    logic [KEY_W-1:0]  keys   [6] = '{20'd400000, 20'd100000, 20'd800000,
                                      20'd50000,  20'd250000, 20'd900000};
    logic              exp_f  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [ADDR_W-1:0] exp_i  [6] = '{3'd3, 3'd0, 3'd7, 3'd0, 3'd0, 3'd0};
    int                exp_c  [6] = '{4, 10, 13, 11, 11, 14};
    int  cyc;
    bit  tmo;
    bit  bok;
    for (int v = 0; v < 6; v++) begin
      do_start(keys[v]);
      checks++;
      if (busy !== 1'b1 || binary_search_done !== 1'b0) begin
        errors++;
        $display("FAIL accept_%0d: got busy=%b done=%b required busy=1 done=0",
                 keys[v], busy, binary_search_done);
      end
      wait_done(39, cyc, tmo, bok);
      checks++;
      if (tmo) begin
        errors++;
        $display("FAIL timeout_%0d: done not seen within 39 cycles", keys[v]);
      end
      checks++;
      if (cyc !== exp_c[v]) begin
        errors++;
        $display("FAIL latency_%0d: got %0d cycles required %0d", keys[v], cyc, exp_c[v]);
      end
      checks++;
      if (binary_search_found !== exp_f[v] || found_index !== exp_i[v]) begin
        errors++;
        $display("FAIL result_%0d: got found=%b idx=%0d required found=%b idx=%0d",
                 keys[v], binary_search_found, found_index, exp_f[v], exp_i[v]);
      end
      checks++;
      if (!bok || busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_%0d: got busy_during_ok=%0b busy_at_done=%b required 1 and 0",
                 keys[v], bok, busy);
      end
    end
  endtask

  task automatic test_busy_ignore_and_hold;
    int cyc;
    bit tmo;
    bit bok;
    bit hold_ok;
    do_start(20'd300000);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    start      = 1'b1;
    target_bin = 20'd700000;
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    wait_done(39, cyc, tmo, bok);
    checks++;
    if (tmo || cyc !== 8) begin
      errors++;
      $display("FAIL ignore_latency: got %0d cycles timeout=%0b required 8", cyc, tmo);
    end
    checks++;
    if (binary_search_found !== 1'b1 || found_index !== 3'd2) begin
      errors++;
      $display("FAIL ignore_result: got found=%b idx=%0d required found=1 idx=2",
               binary_search_found, found_index);
    end
    target_bin = 20'd500000;
    hold_ok    = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLOCK_50);
      if (binary_search_done !== 1'b1 || binary_search_found !== 1'b1 ||
          found_index !== 3'd2 || busy !== 1'b0) hold_ok = 1'b0;
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL hold_100: got unstable outputs, now done=%b found=%b idx=%0d required 1,1,2",
               binary_search_done, binary_search_found, found_index);
    end
  endtask

  task automatic test_restart_from_done;
    int cyc;
    bit tmo;
    bit bok;
    do_start(20'd600000);
    checks++;
    if (binary_search_done !== 1'b0 || binary_search_found !== 1'b0 || found_index !== 3'd0) begin
      errors++;
      $display("FAIL restart_clear: got done=%b found=%b idx=%0d required 0,0,0",
               binary_search_done, binary_search_found, found_index);
    end
    wait_done(39, cyc, tmo, bok);
    checks++;
    if (tmo || cyc !== 7 || binary_search_found !== 1'b1 || found_index !== 3'd5) begin
      errors++;
      $display("FAIL restart_result: got cycles=%0d found=%b idx=%0d required 7,1,5",
               cyc, binary_search_found, found_index);
    end
  endtask

  task automatic test_reset_mid_search;
    int cyc;
    bit tmo;
    bit bok;
    bit quiet;
    do_start(20'd800000);
    repeat (4) @(posedge CLOCK_50);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: got busy=%b required 1", busy);
    end
    #4;
    resetn = 1'b0;
    #1;
    checks++;
    if ({busy, binary_search_done, binary_search_found, found_index} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b found=%b idx=%0d required all 0",
               busy, binary_search_done, binary_search_found, found_index);
    end
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;
    quiet  = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge CLOCK_50);
      if (binary_search_done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL no_partial_result: got done/busy activity after reset, required none");
    end
    do_start(20'd200000);
    wait_done(39, cyc, tmo, bok);
    checks++;
    if (tmo || cyc !== 7 || binary_search_found !== 1'b1 || found_index !== 3'd1) begin
      errors++;
      $display("FAIL post_reset_result: got cycles=%0d found=%b idx=%0d required 7,1,1",
               cyc, binary_search_found, found_index);
    end
  endtask

  initial begin
    resetn     = 1'b0;
    start      = 1'b0;
    target_bin = '0;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      dut.g_rom_blank.r_table[i] = KEY_W'((i + 1) * 100000);
    end
    test_reset;
    test_lookups;
    test_busy_ignore_and_hold;
    test_restart_from_done;
    test_reset_mid_search;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
